digipot_sched: RTL and testbench
================================

DIGIPOT_SCHED -- requirements
Module: digipot_sched

Interface
REQ-001 Parameter XFER_CYCLES, default 40: number of clk cycles ctrl is held low per transfer; must be >= 34, the serial writer's frame length.
REQ-002 Parameter GAP_CYCLES, default 4: number of clk cycles ctrl is held high between transfers; must be >= 1.
REQ-003 Parameter RESET_CODE, default 8'h80: shadow value loaded into every channel by reset.
REQ-004 Parameter REFRESH_CYCLES, default 50_000_000: refresh period in clk cycles; used only when DIGIPOT_REFRESH_EN is defined.
REQ-005 clk  input  1  global 50 MHz clock; the only clock in the block.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  host write strobe, one cycle per write.
REQ-008 wr_addr  input  2  target channel (0..2); the value 3 is ignored.
REQ-009 wr_data  input  8  wiper code to program.
REQ-010 mux  output  2  channel select to the serial writer.
REQ-011 dato  output  8  data word to the serial writer.
REQ-012 ctrl  output  1  start to the serial writer; idle high, low for the duration of a transfer.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when a transfer completes.
REQ-015 pending  output  3  per-channel dirty flags.

Function
REQ-016 The block SHALL hold one 8-bit shadow register and one dirty flag per channel (0..2).
REQ-017 wr_en with wr_addr<3 SHALL, at the clock edge, load the shadow register for that channel and set its dirty flag; wr_addr=3 SHALL change nothing.
REQ-018 The FSM SHALL have four states, IDLE, SETUP, XFER and GAP, and SHALL never occupy any other state.
REQ-019 IDLE->SETUP when any dirty flag is set: latch the selected channel into mux and its shadow into dato, and clear that channel's dirty flag, all on the same edge.
REQ-020 Selection SHALL be round-robin starting after the last serviced channel; after reset the search starts at channel 0.
REQ-021 SETUP SHALL last exactly 1 cycle with ctrl=1, then go to XFER.
REQ-022 XFER SHALL hold ctrl=0 for exactly XFER_CYCLES cycles, then go to GAP.
REQ-023 GAP SHALL hold ctrl=1 for exactly GAP_CYCLES cycles; done=1 on the last GAP cycle, then go to IDLE.
REQ-024 mux and dato SHALL remain constant from the SETUP entry edge through the end of GAP.
REQ-025 A write to the channel being transferred SHALL update its shadow and set its dirty flag again; the current transfer keeps the latched value and a new transfer follows later.
REQ-026 Repeated writes to a dirty channel before it is serviced SHALL coalesce, and only the last value is sent.
REQ-027 Latency: write at edge N in IDLE -> mux/dato valid from N+2, ctrl low on cycles N+3..N+2+XFER_CYCLES.
REQ-028 The cycle counter SHALL be sized to hold max(XFER_CYCLES, GAP_CYCLES, REFRESH_CYCLES) without wrap.

Reset
REQ-029 Reset SHALL set: state=IDLE, ctrl=1, busy=0, done=0, mux=0, dato=0, every shadow=RESET_CODE, pending=3'b111, round-robin pointer to channel 0, all counters=0.
REQ-030 rst asserted mid-transfer SHALL force ctrl=1 on the next edge and abort the transfer; all three channels are then reprogrammed through their reset dirty flags.
REQ-031 rst SHALL take priority over a simultaneous wr_en.

Configuration
REQ-032 With DIGIPOT_REFRESH_EN defined, a free-running counter SHALL set all three dirty flags every REFRESH_CYCLES cycles, so every pot is periodically rewritten with its shadow value.
REQ-033 If a refresh tick coincides with a wr_en, both effects SHALL apply.
REQ-034 Without DIGIPOT_REFRESH_EN, no refresh counter is built and dirty flags are set only by reset and writes.

Verification
REQ-035 Release reset, no writes -> three transfers on channels 0,1,2 in order, each with dato=8'h80, ctrl low for 40 cycles, gaps of 4 cycles, three done pulses.
REQ-036 When idle, write ch1=8'h3C -> mux=1, dato=8'h3C at N+2, ctrl low on N+3..N+42, done at N+46.
REQ-037 During the ch0 transfer, write ch0=8'h11 then ch0=8'h22 -> current dato unchanged; exactly one more ch0 transfer follows, with dato=8'h22.
REQ-038 Write all three channels on consecutive cycles while the FSM is servicing ch1 -> service order after the current transfer is 2,0,1.
REQ-039 Assert rst on XFER cycle 20 -> ctrl=1 next edge, pending=3'b111, full reprogram at 8'h80.
REQ-040 With DIGIPOT_REFRESH_EN and REFRESH_CYCLES=500 -> after the initial programming, all three channels are rewritten with their current shadows every 500 cycles; write with wr_addr=3 -> no effect.

Source files
------------

// File: rtl/digipot_sched.sv
// digipot_sched: shadows three 8-bit wiper codes and schedules serial-writer transfers
// round-robin over the dirty channels (IDLE -> SETUP -> XFER -> GAP). Outputs are registered.
// Optional build macro DIGIPOT_REFRESH_EN adds a periodic refresh that re-dirties all channels.
module digipot_sched #(
  parameter int         XFER_CYCLES    = 40,
  parameter int         GAP_CYCLES     = 4,
  parameter logic [7:0] RESET_CODE     = 8'h80,
  parameter int         REFRESH_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [1:0] mux,
  output logic [7:0] dato,
  output logic       ctrl,
  output logic       busy,
  output logic       done,
  output logic [2:0] pending
);

  // One counter width covers every timed interval so none of them can wrap.
  localparam int CNT_MAX_XG = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_XG > REFRESH_CYCLES) ? CNT_MAX_XG : REFRESH_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;     // first channel examined by the next search
  logic [7:0]    shadow [0:2];
  logic [1:0]    sel;
  logic [2:0]    cand;
  logic [2:0]    wr_set;
  logic [2:0]    svc_clr;
  logic          ref_tick;

`ifdef DIGIPOT_REFRESH_EN
  logic [CW-1:0] ref_cnt;

  assign ref_tick = (ref_cnt == CW'(REFRESH_CYCLES - 1));

  // Free-running refresh period counter; wraps on the tick.
  always_ff @(posedge clk) begin
    if (rst) ref_cnt <= '0;
    else     ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
  end
`else
  assign ref_tick = 1'b0;
`endif

  // Round-robin pick: the first dirty channel at or after rr_ptr (iterating
  // backwards so the nearest candidate is the last, winning assignment).
  always_comb begin
    sel  = rr_ptr;
    cand = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (pending[cand[1:0]]) sel = cand[1:0];
    end
  end

  // Dirty-flag set/clear requests for this edge; a set on the same edge as the
  // service clear wins, so a write to the channel just picked is not lost.
  always_comb begin
    wr_set  = 3'b000;
    svc_clr = 3'b000;
    if (wr_en && wr_addr != 2'd3) wr_set[wr_addr] = 1'b1;
    if (state == IDLE && |pending) svc_clr[sel] = 1'b1;
  end

  // Shadow registers and dirty flags; writes to address 3 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) shadow[i] <= RESET_CODE;
      pending <= 3'b111;
    end else begin
      if (wr_en && wr_addr != 2'd3) shadow[wr_addr] <= wr_data;
      pending <= (pending & ~svc_clr) | wr_set | {3{ref_tick}};
    end
  end

  // Transfer sequencer with registered outputs; mux/dato are only loaded on
  // the IDLE->SETUP edge so they stay frozen for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= 2'd0;
      mux    <= 2'd0;
      dato   <= 8'd0;
      ctrl   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending) begin
            state  <= SETUP;
            mux    <= sel;
            dato   <= shadow[sel];
            rr_ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            busy   <= 1'b1;
            ctrl   <= 1'b1;
          end
        end
        SETUP: begin
          state <= XFER;
          ctrl  <= 1'b0;
          cnt   <= '0;
        end
        XFER: begin
          if (cnt == CW'(XFER_CYCLES - 1)) begin
            state <= GAP;
            ctrl  <= 1'b1;
            cnt   <= '0;
            done  <= (GAP_CYCLES == 1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt  <= cnt + 1'b1;
            // raise done so it is visible during the final gap cycle
            done <= (cnt == CW'(GAP_CYCLES - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digipot_sched.sv
// Bench for digipot_sched: transaction-level model (shadows, dirty set, round-robin
// pointer) updated per edge by a monitor, plus directed latency/order scenarios.
module tb_digipot_sched;
  localparam int XFER = 40;
  localparam int GAP  = 4;
  localparam int REF  = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] mux;
  logic [7:0] dato;
  logic       ctrl, busy, done;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  digipot_sched #(
    .XFER_CYCLES(XFER), .GAP_CYCLES(GAP), .RESET_CODE(8'h80), .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mux(mux), .dato(dato), .ctrl(ctrl), .busy(busy), .done(done), .pending(pending)
  );

  // reference model
  logic [7:0] m_shadow [0:2];
  logic [2:0] m_dirty;
  int         m_ptr;
  int         ref_age;
  // per-transfer trackers
  logic       prev_busy;
  int         low_len, gap_len, done_cnt, n_done;
  logic [1:0] lat_mux;
  logic [7:0] lat_dato;
  int         xfer_log[$];
  logic [7:0] dato_log[$];

  // Monitor: capture inputs at the edge, outputs 1 time unit later, and advance the model.
  always @(posedge clk) begin
    logic       c_rst, c_wr;
    logic [1:0] c_a;
    logic [7:0] c_d;
    logic [2:0] pre_dirty;
    int         ch, c;
    c_rst = rst; c_wr = wr_en; c_a = wr_addr; c_d = wr_data;
    #1;
    if (c_rst) begin
      checks++;
      if ({ctrl, busy, done, mux, dato} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
        errors++;
        $display("FAIL reset_outputs ctrl=%b busy=%b done=%b mux=%0d dato=%h, need 1 0 0 0 00",
                 ctrl, busy, done, mux, dato);
      end
      for (int i = 0; i < 3; i++) m_shadow[i] = 8'h80;
      m_dirty = 3'b111; m_ptr = 0; ref_age = 0;
      prev_busy = 1'b0; low_len = 0; gap_len = 0; done_cnt = 0;
    end else begin
      pre_dirty = m_dirty;
      ref_age++;
      if (!prev_busy && busy) begin
        ch = -1;
        for (int k = 0; k < 3; k++) begin
          c = (m_ptr + k) % 3;
          if (ch < 0 && m_dirty[c]) ch = c;
        end
        checks++;
        if (ch < 0) begin
          errors++;
          $display("FAIL spurious_start mux=%0d dato=%h with nothing dirty", mux, dato);
        end else begin
          if (mux !== 2'(ch) || dato !== m_shadow[ch] || ctrl !== 1'b1) begin
            errors++;
            $display("FAIL start mux=%0d dato=%h ctrl=%b, need mux=%0d dato=%h ctrl=1",
                     mux, dato, ctrl, ch, m_shadow[ch]);
          end
          m_dirty[ch] = 1'b0;
          m_ptr = (ch + 1) % 3;
        end
        xfer_log.push_back(int'(mux));
        dato_log.push_back(dato);
        lat_mux = mux; lat_dato = dato;
        low_len = 0; gap_len = 0; done_cnt = 0;
      end else if (!prev_busy && !busy) begin
        checks++;
        if (pre_dirty != 3'b000 || ctrl !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL idle dirty=%b ctrl=%b done=%b, need no dirty, ctrl=1 done=0",
                   pre_dirty, ctrl, done);
        end
      end else if (prev_busy && busy) begin
        checks++;
        if (mux !== lat_mux || dato !== lat_dato) begin
          errors++;
          $display("FAIL hold mux=%0d dato=%h, need %0d %h", mux, dato, lat_mux, lat_dato);
        end
        if (!ctrl) begin
          if (gap_len != 0) begin
            checks++; errors++;
            $display("FAIL ctrl_relow got low after %0d gap cycles, need high", gap_len);
          end
          low_len++;
        end else if (low_len > 0) begin
          gap_len++;
        end
        if (done) begin
          done_cnt++;
          checks++;
          if (gap_len != GAP) begin
            errors++;
            $display("FAIL done_timing done at gap cycle %0d, need %0d", gap_len, GAP);
          end
        end
      end else begin
        checks++;
        if (low_len != XFER || gap_len != GAP || done_cnt != 1) begin
          errors++;
          $display("FAIL frame low=%0d gap=%0d dones=%0d, need %0d %0d 1",
                   low_len, gap_len, done_cnt, XFER, GAP);
        end
        n_done++;
      end
      if (c_wr && c_a != 2'd3) begin
        m_shadow[c_a] = c_d;
        m_dirty[c_a]  = 1'b1;
      end
`ifdef DIGIPOT_REFRESH_EN
      if (ref_age % REF == 0) m_dirty = 3'b111;
`endif
      checks++;
      if (pending !== m_dirty) begin
        errors++;
        $display("FAIL pending got %b, need %b", pending, m_dirty);
      end
      prev_busy = busy;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((busy || pending != 3'b000) && n < budget) begin step(); n++; end
    checks++;
    if (busy || pending != 3'b000) begin
      errors++;
      $display("FAIL drain_timeout busy=%b pending=%b after %0d cycles, need idle", busy, pending, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    repeat (3) step();
    checks++;
    if (pending !== 3'b111 || ctrl !== 1'b1 || busy !== 1'b0 || dato !== 8'd0) begin
      errors++;
      $display("FAIL reset_state pending=%b ctrl=%b busy=%b dato=%h, need 111 1 0 00",
               pending, ctrl, busy, dato);
    end
    xfer_log.delete(); dato_log.delete(); n_done = 0;
    rst = 1'b0;
    wait_drain(500);
    checks++;
    if (xfer_log.size() != 3 || n_done != 3) begin
      errors++;
      $display("FAIL power_on_count transfers=%0d dones=%0d, need 3 3", xfer_log.size(), n_done);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xfer_log[i] != i || dato_log[i] !== 8'h80) begin
          errors++;
          $display("FAIL power_on_%0d ch=%0d dato=%h, need ch=%0d dato=80", i, xfer_log[i], dato_log[i], i);
        end
      end
    end
  endtask

  task automatic test_single_write();
    logic exp_ctrl, exp_done;
    do_write(2'd1, 8'h3C);
    step();
    checks++;
    if (mux !== 2'd1 || dato !== 8'h3C || busy !== 1'b1 || ctrl !== 1'b1) begin
      errors++;
      $display("FAIL latency_setup mux=%0d dato=%h busy=%b ctrl=%b, need 1 3c 1 1", mux, dato, busy, ctrl);
    end
    for (int k = 2; k <= 45; k++) begin
      step();
      exp_ctrl = !(k >= 2 && k <= 41);
      exp_done = (k == 45);
      checks++;
      if (ctrl !== exp_ctrl || done !== exp_done) begin
        errors++;
        $display("FAIL latency_k%0d ctrl=%b done=%b, need %b %b", k, ctrl, done, exp_ctrl, exp_done);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL latency_end busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_coalesce();
    xfer_log.delete(); dato_log.delete();
    do_write(2'd0, 8'h55);
    repeat (10) step();
    do_write(2'd0, 8'h11);
    do_write(2'd0, 8'h22);
    checks++;
    if (dato !== 8'h55 || pending !== 3'b001) begin
      errors++;
      $display("FAIL coalesce_hold dato=%h pending=%b, need 55 001", dato, pending);
    end
    wait_drain(300);
    checks++;
    if (xfer_log.size() != 2 || xfer_log[0] != 0 || xfer_log[1] != 0 || dato_log[1] !== 8'h22) begin
      errors++;
      $display("FAIL coalesce_seq transfers=%0d last_dato=%h, need 2 transfers on ch0 ending 22",
               xfer_log.size(), dato_log[dato_log.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    int         exp_ch [4];
    logic [7:0] exp_d  [4];
    exp_ch = '{1, 2, 0, 1};
    exp_d  = '{8'hA1, 8'hB2, 8'hB0, 8'hB1};
    xfer_log.delete(); dato_log.delete();
    do_write(2'd1, 8'hA1);
    repeat (5) step();
    do_write(2'd0, 8'hB0);
    do_write(2'd1, 8'hB1);
    do_write(2'd2, 8'hB2);
    wait_drain(600);
    checks++;
    if (xfer_log.size() != 4) begin
      errors++;
      $display("FAIL rr_count transfers=%0d, need 4", xfer_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (xfer_log[i] != exp_ch[i] || dato_log[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL rr_order_%0d ch=%0d dato=%h, need ch=%0d dato=%h",
                   i, xfer_log[i], dato_log[i], exp_ch[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(2'd2, 8'h5A);
    repeat (21) step();
    checks++;
    if (ctrl !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_xfer ctrl=%b, need 0", ctrl);
    end
    rst = 1'b1;
    step();
    checks++;
    if (ctrl !== 1'b1 || pending !== 3'b111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ctrl=%b pending=%b busy=%b, need 1 111 0", ctrl, pending, busy);
    end
    xfer_log.delete(); dato_log.delete();
    rst = 1'b0;
    wait_drain(500);
    checks++;
    if (xfer_log.size() != 3 || xfer_log[0] != 0 || xfer_log[1] != 1 || xfer_log[2] != 2 ||
        dato_log[0] !== 8'h80 || dato_log[1] !== 8'h80 || dato_log[2] !== 8'h80) begin
      errors++;
      $display("FAIL mid_reprogram transfers=%0d, need ch 0,1,2 all at 80", xfer_log.size());
    end
  endtask

  task automatic test_addr3();
    do_write(2'd3, 8'hFF);
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || pending !== 3'b000) begin
      errors++;
      $display("FAIL addr3 busy=%b pending=%b, need 0 000", busy, pending);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 50)) step();
      do_write(2'($urandom_range(0, 3)), 8'($urandom));
    end
    wait_drain(1000);
    checks++;
    if (m_dirty !== 3'b000) begin
      errors++;
      $display("FAIL random_end model dirty=%b, need 000", m_dirty);
    end
  endtask

`ifdef DIGIPOT_REFRESH_EN
  task automatic test_refresh();
    int n = 0;
    xfer_log.delete(); dato_log.delete();
    while (xfer_log.size() < 6 && n < 1500) begin step(); n++; end
    checks++;
    if (xfer_log.size() < 6) begin
      errors++;
      $display("FAIL refresh transfers=%0d within %0d cycles, need 6", xfer_log.size(), n);
    end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef DIGIPOT_REFRESH_EN
    test_addr3();
    test_refresh();
    test_random();
`else
    test_single_write();
    test_coalesce();
    test_back_to_back();
    test_reset_mid();
    test_addr3();
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
